// File: rtl/controlador_display_pkg.sv
// Shared definitions for the 4-digit 7-segment display controller.
//   SEG_BLANK : all segments off (active-low bus)
//   AN_OFF    : all anodes off (active-low)
//   state_t   : message arbitration state (base message / alternate message)
package controlador_display_pkg;

    localparam logic [0:6] SEG_BLANK = 7'b1111111;
    localparam logic [3:0] AN_OFF    = 4'b1111;

    typedef enum logic {
        ST_BASE = 1'b0,
        ST_ALT  = 1'b1
    } state_t;

endpackage

// File: rtl/controlador_display_divisor_refresco.sv
// Refresh prescaler: free-running counter 0..PRESCALE-1 that emits a
// single-cycle tick on the terminal count, marking the end of a digit slot.
// Ports:
//   clk   in  system clock
//   reset in  synchronous, active-high
//   tick  out high during the count == PRESCALE-1 cycle
module divisor_refresco #(
    parameter int PRESCALE = 50000
) (
    input  logic clk,
    input  logic reset,
    output logic tick
);

    localparam int          CW   = $clog2(PRESCALE);
    localparam logic [CW-1:0] LAST = CW'(PRESCALE - 1);

    logic [CW-1:0] count;

    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (count == LAST) begin
            count <= '0;
        end else begin
            count <= count + 1'b1;
        end
    end

    assign tick = (count == LAST);

endmodule

// File: rtl/controlador_display.sv
// 4-digit 7-segment display sequencer.
// Time-multiplexes the four decoded digit patterns onto a shared segment bus
// with active-low anodes, and arbitrates between a persistent base message
// and a latched alternate message shown for HOLD_TICKS digit slots.
// Ports:
//   clk, reset      system clock, synchronous active-high reset
//   msg_base[31:0]  base message, 4 ASCII bytes, [7:0] = rightmost digit
//   msg_alt[31:0]   alternate message, same format
//   alt_req         1-cycle request to show msg_alt
//   mensaje[31:0]   message sent to the external ASCII-to-segment separator
//   parte_0..3      decoded patterns back from the separator, [0:6]=a..g, active-low
//   seg[0:6]        registered segment bus, active-low
//   an[3:0]         registered anodes, active-low one-hot, an[0] = parte_0
//   alt_busy        high while the alternate message is displayed
module controlador_display
    import controlador_display_pkg::*;
#(
    parameter int PRESCALE   = 50000,
    parameter int HOLD_TICKS = 2000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] msg_base,
    input  logic [31:0] msg_alt,
    input  logic        alt_req,
    output logic [31:0] mensaje,
    input  logic [0:6]  parte_0,
    input  logic [0:6]  parte_1,
    input  logic [0:6]  parte_2,
    input  logic [0:6]  parte_3,
    output logic [0:6]  seg,
    output logic [3:0]  an,
    output logic        alt_busy
);

    localparam int            HW        = $clog2(HOLD_TICKS + 1);
    localparam logic [HW-1:0] HOLD_LOAD = HW'(HOLD_TICKS);
    localparam logic [HW-1:0] HOLD_LAST = HW'(1);

    logic          tick;
    logic [1:0]    idx;
    state_t        state_q, state_d;
    logic [HW-1:0] hold_q, hold_d;
    logic [31:0]   alt_q, alt_d;
    logic [0:6]    seg_sel;

    divisor_refresco #(
        .PRESCALE (PRESCALE)
    ) u_divisor (
        .clk   (clk),
        .reset (reset),
        .tick  (tick)
    );

    // Digit index advances once per slot.
    always_ff @(posedge clk) begin
        if (reset) begin
            idx <= '0;
        end else if (tick) begin
            idx <= idx + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_BASE;
            hold_q  <= '0;
            alt_q   <= '0;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
            alt_q   <= alt_d;
        end
    end

    // A new request always wins over a coinciding hold expiry: it relatches
    // and restarts the hold count instead of returning to the base message.
    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        alt_d   = alt_q;
        unique case (state_q)
            ST_BASE: begin
                if (alt_req) begin
                    alt_d   = msg_alt;
                    hold_d  = HOLD_LOAD;
                    state_d = ST_ALT;
                end
            end
            ST_ALT: begin
                if (alt_req) begin
                    alt_d  = msg_alt;
                    hold_d = HOLD_LOAD;
                end else if (tick) begin
                    hold_d = hold_q - 1'b1;
                    if (hold_q == HOLD_LAST) begin
                        state_d = ST_BASE;
                    end
                end
            end
            default: state_d = ST_BASE;
        endcase
    end

    assign alt_busy = (state_q == ST_ALT);
    assign mensaje  = alt_busy ? alt_q : msg_base;

    always_comb begin
        seg_sel = SEG_BLANK;
        unique case (idx)
            2'd0: seg_sel = parte_0;
            2'd1: seg_sel = parte_1;
            2'd2: seg_sel = parte_2;
            2'd3: seg_sel = parte_3;
            default: seg_sel = SEG_BLANK;
        endcase
    end

    // Pins reflect the index of the previous cycle (one cycle of latency).
    always_ff @(posedge clk) begin
        if (reset) begin
            an  <= AN_OFF;
            seg <= SEG_BLANK;
        end else begin
            an  <= ~(4'b0001 << idx);
            seg <= seg_sel;
        end
    end

endmodule
